// File: rtl/dcache_ctrl_if.sv
// CPU-side and memory-side signal bundle for the data cache controller.
// The master side is the datapath plus main memory; the slave side is the cache.
interface dcache_ctrl_if #(
   parameter int unsigned BLOCK_WORDS = 4
);
   logic                        MemRead;
   logic                        MemWrite;
   logic [31:0]                 DataAdr;
   logic [31:0]                 WriteData;
   logic [31:0]                 ReadData;
   logic                        stall;
   logic                        mem_rd_req;
   logic                        mem_wr_req;
   logic [31:0]                 mem_addr;
   logic [31:0]                 mem_wdata;
   logic [32*BLOCK_WORDS-1:0]   mem_rdata;
   logic                        mem_ready;

   modport master (
      output MemRead, MemWrite, DataAdr, WriteData, mem_rdata, mem_ready,
      input  ReadData, stall, mem_rd_req, mem_wr_req, mem_addr, mem_wdata
   );

   modport slave (
      input  MemRead, MemWrite, DataAdr, WriteData, mem_rdata, mem_ready,
      output ReadData, stall, mem_rd_req, mem_wr_req, mem_addr, mem_wdata
   );
endinterface

// File: rtl/dcache_ctrl.sv
// Direct-mapped, write-through, no-write-allocate data cache with its controller.
// Load hits return in the same cycle; misses and all stores stall the PC.
module dcache_ctrl #(
   parameter int unsigned INDEX_W     = 5,
   parameter int unsigned BLOCK_WORDS = 4
) (
   input  logic         clk,
   input  logic         rst,
   dcache_ctrl_if.slave bus
);
   localparam int unsigned OFF_W = $clog2(BLOCK_WORDS);
   localparam int unsigned TAG_W = 32 - INDEX_W - OFF_W - 2;
   localparam int unsigned LINES = 1 << INDEX_W;

   typedef enum logic [1:0] {IDLE, FILL, WRITE, WDONE} state_e;

   state_e             state_q, state_d;
   logic [31:2]        addr_q, addr_d;
   logic [31:0]        wdata_q, wdata_d;
   logic               wr_hit_q, wr_hit_d;
   logic [LINES-1:0]   valid_q, valid_d;
   logic [31:0]        data_q [LINES][BLOCK_WORDS];
   logic [TAG_W-1:0]   tag_q  [LINES];
   logic               fill_we, word_we;

   logic [OFF_W-1:0]   cpu_off, lat_off;
   logic [INDEX_W-1:0] cpu_idx, lat_idx;
   logic [TAG_W-1:0]   cpu_tag, lat_tag;
   logic               cpu_hit;
   logic               unused_adr_lsb;

   assign cpu_off = bus.DataAdr[OFF_W+1:2];
   assign cpu_idx = bus.DataAdr[OFF_W+INDEX_W+1:OFF_W+2];
   assign cpu_tag = bus.DataAdr[31:OFF_W+INDEX_W+2];
   assign lat_off = addr_q[OFF_W+1:2];
   assign lat_idx = addr_q[OFF_W+INDEX_W+1:OFF_W+2];
   assign lat_tag = addr_q[31:OFF_W+INDEX_W+2];
   assign cpu_hit = valid_q[cpu_idx] && (tag_q[cpu_idx] == cpu_tag);
   assign unused_adr_lsb = ^bus.DataAdr[1:0];

   // Next state, latches and bus outputs; a reset cycle abandons any transaction.
   always_comb begin
      state_d        = state_q;
      addr_d         = addr_q;
      wdata_d        = wdata_q;
      wr_hit_d       = wr_hit_q;
      valid_d        = valid_q;
      fill_we        = 1'b0;
      word_we        = 1'b0;
      bus.stall      = 1'b0;
      bus.ReadData   = '0;
      bus.mem_rd_req = 1'b0;
      bus.mem_wr_req = 1'b0;
      bus.mem_addr   = '0;
      bus.mem_wdata  = '0;

      unique case (state_q)
         IDLE: begin
            if (!rst) begin
               if (bus.MemWrite) begin
                  bus.stall = 1'b1;
                  state_d   = WRITE;
                  addr_d    = bus.DataAdr[31:2];
                  wdata_d   = bus.WriteData;
                  wr_hit_d  = cpu_hit;
               end else if (bus.MemRead) begin
                  if (cpu_hit) begin
                     bus.ReadData = data_q[cpu_idx][cpu_off];
                  end else begin
                     bus.stall = 1'b1;
                     state_d   = FILL;
                     addr_d    = {bus.DataAdr[31:OFF_W+2], {OFF_W{1'b0}}};
                  end
               end
            end
         end
         FILL: begin
            bus.stall      = 1'b1;
            bus.mem_rd_req = 1'b1;
            bus.mem_addr   = {addr_q, 2'b00};
            if (bus.mem_ready && !rst) begin
               fill_we          = 1'b1;
               valid_d[lat_idx] = 1'b1;
               state_d          = IDLE;
            end
         end
         WRITE: begin
            bus.stall      = 1'b1;
            bus.mem_wr_req = 1'b1;
            bus.mem_addr   = {addr_q, 2'b00};
            bus.mem_wdata  = wdata_q;
            if (bus.mem_ready && !rst) begin
               word_we = wr_hit_q;
               state_d = WDONE;
            end
         end
         WDONE: state_d = IDLE;
         default: state_d = IDLE;
      endcase

      if (rst) begin
         state_d = IDLE;
         valid_d = '0;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q  <= IDLE;
         valid_q  <= '0;
         addr_q   <= '0;
         wdata_q  <= '0;
         wr_hit_q <= 1'b0;
      end else begin
         state_q  <= state_d;
         valid_q  <= valid_d;
         addr_q   <= addr_d;
         wdata_q  <= wdata_d;
         wr_hit_q <= wr_hit_d;
      end
   end

   // Data and tag arrays are never cleared; the valid bits guard them.
   always_ff @(posedge clk) begin
      if (fill_we) begin
         for (int unsigned i = 0; i < BLOCK_WORDS; i++) begin
            data_q[lat_idx][i] <= bus.mem_rdata[32*i +: 32];
         end
         tag_q[lat_idx] <= lat_tag;
      end
      if (word_we) begin
         data_q[lat_idx][lat_off] <= wdata_q;
      end
   end
endmodule

// File: doc/dcache_ctrl.md
Name: dcache_ctrl

Overview:
- One-level, direct-mapped data cache with its controller, sitting directly downstream of the single-cycle RISC-V datapath.
- Consumes the datapath's load/store address (DataAdr) and store data (WriteData), and returns ReadData.
- Drives the stall input of the PC register while a memory transaction is outstanding.
- Policy: write-through, no-write-allocate. Block refills come from main memory over a request/ready handshake.

Parameters:
- INDEX_W, 5, index bits (2^INDEX_W lines).
- BLOCK_WORDS, 4, 32-bit words per block (power of 2, ≥2); OFF_W = log2(BLOCK_WORDS).
- TAG_W, 32-INDEX_W-OFF_W-2, tag width (derived, not overridden).

Ports:
- clk  in  1  system clock, all state on rising edge.
- rst  in  1  synchronous, active-high reset.
- MemRead  in  1  load in current instruction.
- MemWrite  in  1  store in current instruction.
- DataAdr  in  32  byte address from ALU (word aligned; bits[1:0] ignored).
- WriteData  in  32  store data.
- ReadData  out  32  load data to result mux.
- stall  out  1  holds PC while high.
- mem_rd_req  out  1  block read request to memory.
- mem_wr_req  out  1  word write request to memory.
- mem_addr  out  32  memory address (block-aligned for reads, word address for writes).
- mem_wdata  out  32  write data to memory.
- mem_rdata  in  32*BLOCK_WORDS  refill block; word i at bits [32i+31:32i].
- mem_ready  in  1  memory completes current request this cycle.

Behaviour:
- Address split: offset = [OFF_W+1:2], index = [OFF_W+INDEX_W+1:OFF_W+2], tag = [31:OFF_W+INDEX_W+2].
- Storage per line: valid bit, tag, BLOCK_WORDS data words. hit = valid[index] && tag match.
- Reset (rst high at an edge): all valid bits cleared, state goes to IDLE. Data and tag arrays are not cleared.
- While in reset, and in IDLE with no request: stall=0, mem_rd_req=0, mem_wr_req=0, ReadData=0.
- States: IDLE, FILL, WRITE, WDONE.
- IDLE:
  - Read hit: ReadData = cached word, combinational in the same cycle; stall=0; state stays IDLE.
  - Read miss: stall=1 combinationally; next state FILL; latch block-aligned address.
  - MemWrite (hit or miss): stall=1; next state WRITE; latch word address and WriteData.
  - MemRead and MemWrite both high: write takes priority.
  - Neither asserted: stall=0, ReadData=0.
- FILL:
  - mem_rd_req=1; mem_addr = latched block address, stable until mem_ready; stall=1.
  - On mem_ready: write mem_rdata into the line, set valid, write tag; next state IDLE.
  - The re-presented load then hits in IDLE with stall=0.
  - Read miss penalty = memory latency + 1 cycles.
- WRITE:
  - mem_wr_req=1; mem_addr and mem_wdata stable; stall=1.
  - On mem_ready: if the line was a hit when the request was latched, update that word in the cache (valid and tag unchanged); next state WDONE.
  - A miss does not allocate.
- WDONE:
  - stall=0, no requests, ReadData=0. This lets the PC advance past the store; next state IDLE.
  - This prevents the same store being reissued.
- mem_ready is ignored in IDLE and WDONE. Earliest legal mem_ready is the first cycle mem_*_req is high.
- mem_rd_req and mem_wr_req are never high together.
- Reset mid-FILL or mid-WRITE:
  - Transaction abandoned: no line written, valid bits cleared.
  - Requests drop in the cycle after the reset edge.
  - A mem_ready coinciding with the reset edge is ignored.
- Conflict: a miss to an index holding a valid line with a different tag overwrites that line on refill. No writeback is needed (write-through).

Test Plan:
- Cold load from 0x0000_0040, memory returns block {0x11,0x22,0x33,0x44} with mem_ready in the 3rd FILL cycle:
  - stall high for 4 cycles; mem_addr=0x40 throughout FILL.
  - Cycle 5: stall=0, ReadData=0x11.
- After that fill, load 0x0000_004C → same-cycle hit, stall=0, ReadData=0x44, no mem request.
- Store 0xDEAD_BEEF to 0x0000_0044 (hit), mem_ready after 2 cycles:
  - mem_wr_req with addr 0x44, wdata 0xDEADBEEF; stall high 3 cycles, then WDONE with stall=0.
  - Subsequent load of 0x44 hits and returns 0xDEADBEEF.
- Store to 0x0000_0100 (miss):
  - Write-through seen on memory port.
  - Later load of 0x100 misses and raises mem_rd_req (no allocate).
- Load 0x0000_0240 (index 4, tag 1) after the 0x40 fill:
  - Miss, refill replaces the line.
  - Reload of 0x40 misses again.
- Assert rst during the 2nd FILL cycle:
  - mem_rd_req=0 and stall=0 next cycle.
  - Load 0x40 after reset misses (valid cleared).
